// File: rtl/toggle_gen.sv
// rtl/toggle_gen.sv - square-wave generator producing a programmed number of output edges
// Two-state FSM; every output is a flop so nothing combinational reaches a, busy or done.
module toggle_gen #(
  parameter int CNT_W = 8,
  parameter int TOG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_period,
  input  logic [TOG_W-1:0] num_toggles,
  output logic             a,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TOG_W-1:0] r_tog;
  logic [CNT_W-1:0] r_hp;
  logic [TOG_W-1:0] r_nt;

  logic             w_wrap;
  logic [TOG_W-1:0] w_tog_next;
  logic             w_last;

  // r_hp is never 0, so hp-1 cannot underflow
  assign w_wrap     = (r_cnt == (r_hp - CNT_W'(1)));
  assign w_tog_next = r_tog + TOG_W'(1);
  assign w_last     = (r_nt != '0) && (w_tog_next == r_nt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tog   <= '0;
      r_hp    <= CNT_W'(1);
      r_nt    <= '0;
      a       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_state <= ST_RUN;
            r_hp    <= (half_period == '0) ? CNT_W'(1) : half_period;
            r_nt    <= num_toggles;
            r_cnt   <= '0;
            r_tog   <= '0;
            a       <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          // stop outranks any toggle falling on the same edge
          if (stop) begin
            r_state <= ST_IDLE;
            a       <= 1'b0;
            busy    <= 1'b0;
          end else if (w_wrap) begin
            r_cnt <= '0;
            a     <= ~a;
            r_tog <= w_tog_next;
            if (w_last) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_gen.sv
// tb/tb_toggle_gen.sv - directed bench for toggle_gen
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_toggle_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] half_period;
  logic [7:0] num_toggles;
  logic       a;
  logic       busy;
  logic       done;

  int total;
  int bad;

  toggle_gen #(.CNT_W(8), .TOG_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .num_toggles (num_toggles),
    .a           (a),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected a after edge k of the hp=5, nt=4 waveform
  function automatic logic exp_a5(input int k);
    return ((k >= 5 && k < 10) || (k >= 15 && k < 20)) ? 1'b1 : 1'b0;
  endfunction

  task automatic run_hp5(input string tag, input bit disturb);
    half_period = 8'd5;
    num_toggles = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_e0_busy"}, busy, 1);
    chk({tag, "_e0_a"}, a, 0);
    for (int k = 1; k <= 20; k++) begin
      if (disturb && k == 3) begin
        start = 1'b1;
        half_period = 8'd9;
        num_toggles = 8'd1;
      end
      tick();
      start = 1'b0;
      chk($sformatf("%s_e%0d_a", tag, k), a, exp_a5(k));
      chk($sformatf("%s_e%0d_busy", tag, k), busy, (k < 20) ? 1 : 0);
      chk($sformatf("%s_e%0d_done", tag, k), done, (k == 20) ? 1 : 0);
    end
    tick();
    chk({tag, "_post_done"}, done, 0);
    chk({tag, "_post_a"}, a, 0);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    half_period = 8'd0;
    num_toggles = 8'd0;
    #1;
    chk("rst_a", a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst = 1'b0;

    // basic hp=5, nt=4 waveform
    run_hp5("base", 1'b0);

    // start re-pulse and input changes mid-run are ignored
    run_hp5("ignore", 1'b1);

    // half_period 0 behaves as 1
    half_period = 8'd0;
    num_toggles = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("hp0_e%0d_a", k), a, k[0]);
      chk($sformatf("hp0_e%0d_done", k), done, (k == 3) ? 1 : 0);
      chk($sformatf("hp0_e%0d_busy", k), busy, (k < 3) ? 1 : 0);
    end
    tick();
    chk("hp0_hold_a", a, 1);
    chk("hp0_hold_done", done, 0);

    // continuous run, stopped at E9
    half_period = 8'd2;
    num_toggles = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("cont_e%0d_a", k), a, (k / 2) % 2);
      chk($sformatf("cont_e%0d_busy", k), busy, 1);
      chk($sformatf("cont_e%0d_done", k), done, 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_a", a, 0);
    chk("cont_stop_busy", busy, 0);
    chk("cont_stop_done", done, 0);
    tick();
    chk("cont_after_done", done, 0);

    // toggle counter wraps with no effect when nt=0
    half_period = 8'd1;
    num_toggles = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (busy !== 1'b1 || a !== k[0] || done !== 1'b0)
        chk($sformatf("wrap_e%0d_a_busy_done", k), {a, busy, done}, {k[0], 1'b1, 1'b0});
    end
    chk("wrap_end_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wrap_stop_busy", busy, 0);

    // asynchronous reset mid-run, then a clean restart
    half_period = 8'd5;
    num_toggles = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    chk("arst_pre_a", a, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_a", a, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    rst = 1'b0;
    #1;
    run_hp5("restart", 1'b0);

    // start together with stop in IDLE is refused
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("both_busy", busy, 0);
    chk("both_a", a, 0);
    tick();
    chk("both_busy2", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toggle_gen.md
TOGGLE_GEN -- requirements
Module: toggle_gen

Interface
REQ-001 Parameter: CNT_W, default 8, width of the half-period field and counter.
REQ-002 Parameter: TOG_W, default 8, width of the toggle-count field and counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin a waveform; sampled only in IDLE.
REQ-006 stop  input  1  abort request; sampled in RUN.
REQ-007 half_period  input  CNT_W  clk cycles per output level; sampled on the accepted start.
REQ-008 num_toggles  input  TOG_W  output edges to produce; 0 = continuous; sampled on the accepted start.
REQ-009 a  output  1  registered square wave; drives the downstream buffer input.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse on normal completion.

Function
REQ-012 FSM SHALL have two states: IDLE and RUN.
REQ-013 IDLE with start=1 and stop=0 SHALL, at that edge, enter RUN and:
- latch hp_q = half_period, with 0 mapped to 1;
- latch nt_q = num_toggles;
- clear the cycle counter and the toggle counter;
- force a=0;
- set busy=1.
REQ-014 IDLE with start=1 and stop=1 SHALL remain in IDLE; stop has priority.
REQ-015 In RUN, each edge with cnt != hp_q-1 SHALL increment cnt by 1 and leave a unchanged.
REQ-016 In RUN, an edge with cnt == hp_q-1 SHALL:
- clear cnt;
- invert a;
- increment the toggle counter (modulo 2^TOG_W).
REQ-017 The first edge of a SHALL appear hp_q edges after the start edge; successive edges SHALL be hp_q edges apart (period 2*hp_q).
REQ-018 If nt_q != 0 and the toggle at REQ-016 is the nt_q-th, the same edge SHALL:
- move FSM to IDLE;
- set busy=0;
- set done=1.
REQ-019 done SHALL be 1 for exactly one cycle and 0 otherwise.
REQ-020 After completion, a SHALL hold its final level: 1 if nt_q is odd, 0 if even. It changes only at the next accepted start or reset.
REQ-021 When nt_q == 0, RUN SHALL continue indefinitely; toggle-counter wrap SHALL have no effect.
REQ-022 stop=1 in RUN SHALL take priority over any toggle at that edge and SHALL:
- set a=0;
- move FSM to IDLE;
- set busy=0;
- leave done=0.
REQ-023 start in RUN SHALL be ignored.
REQ-024 half_period and num_toggles changes during RUN SHALL have no effect until the next accepted start.
REQ-025 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, set:
- FSM=IDLE;
- a=0, busy=0, done=0;
- cnt=0, toggle counter=0;
- hp_q=1, nt_q=0.
REQ-027 rst asserted mid-RUN SHALL abort with no done pulse.
REQ-028 After rst deasserts, the block SHALL accept start at the first following rising edge.

Verification
REQ-029 half_period=5, num_toggles=4, start pulsed at edge E0 -> a rises at E5, falls at E10, rises at E15, falls at E20; done=1 only in the cycle after E20; busy 1 from E0 to E20; final a=0.
REQ-030 half_period=0, num_toggles=3 -> a toggles at E1, E2, E3 (treated as 1); done after E3; final a=1.
REQ-031 half_period=2, num_toggles=0, stop at E9 -> a toggles at E2, E4, E6, E8; a=0, busy=0 after E9; done never asserts.
REQ-032 start re-pulsed at E3 during a half_period=5 run; half_period changed to 9 mid-run -> waveform unchanged from REQ-029.
REQ-033 rst asserted asynchronously between E7 and E8 of the REQ-029 run -> a, busy, done drop to 0 immediately; a new start after release produces the REQ-029 waveform from its own E0.
REQ-034 start=1 and stop=1 together in IDLE -> busy stays 0 and a stays 0.
